// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Each access runs grant -> one memory cycle -> response. Out-of-range word
// addresses are flagged and never write the memory.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rerr0,
  output logic              rerr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // One extra bit so the range check never wraps, whatever DEPTH is.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t              state, state_nxt;
  logic                last_port;
  logic                port_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_range;
  logic                any_req;
  logic                win;
  logic                grant;
  logic [DATA_W-1:0]   cap_data;

  assign in_range = {1'b0, addr_q} < DEPTH_X;
  assign any_req  = req0 | req1;
  // On a tie the port that did not win last time takes it.
  assign win      = (req0 & req1) ? ~last_port : req1;
  // Reads in range return memory data; writes and bad addresses return zero.
  assign cap_data = (!we_q && in_range) ? mem_read_data : '0;

  // Next state, grant and memory/response strobes.
  always_comb begin
    state_nxt       = state;
    grant           = 1'b0;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    rvalid0         = 1'b0;
    rvalid1         = 1'b0;
    rerr0           = 1'b0;
    rerr1           = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    case (state)
      IDLE, RESP: begin
        if (state == RESP) begin
          rvalid0 = ~port_q;
          rvalid1 = port_q;
          rerr0   = ~port_q & ~in_range;
          rerr1   = port_q & ~in_range;
        end
        // Grant is combinational; gate by reset so outputs drop immediately.
        if (any_req && !rst) begin
          grant     = 1'b1;
          gnt0      = ~win;
          gnt1      = win;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        mem_access_addr = addr_q;
        if (we_q) begin
          mem_write_data = wdata_q;
          mem_write_en   = in_range;
        end
        state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the winning request and remember who won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_port <= 1'b1;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (grant) begin
      last_port <= win;
      port_q    <= win;
      we_q      <= win ? we1 : we0;
      addr_q    <= win ? addr1 : addr0;
      wdata_q   <= win ? wdata1 : wdata0;
    end
  end

  // Capture response data at the end of the memory cycle; held until next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS) begin
      if (port_q) rdata1 <= cap_data;
      else        rdata0 <= cap_data;
    end
  end

endmodule
